// File: rtl/scan_chain_pkg.sv
// Shared types for the scan-chain load controller.
package scan_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/scan_chain_readback.sv
// Packs the bits returning from the chain tail into words, LSB-first.
// A short final word is emitted zero-padded in its upper bits.
module scan_chain_readback #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  sample_en,
  input  logic                  last_sample,
  input  logic                  scan_out,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid
);

  localparam int PCNT_W = $clog2(WORD_WIDTH + 1);

  logic [WORD_WIDTH-1:0] acc_q, acc_d;
  logic [WORD_WIDTH-1:0] rb_data_q;
  logic [PCNT_W-1:0]     pos_q;
  logic                  rb_valid_q;

  // Merge the current tail bit into the partially packed word.
  always_comb begin
    acc_d = acc_q | (WORD_WIDTH'(scan_out) << pos_q);
  end

  // Accumulate samples; emit a word when full or when the chain is exhausted.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc_q      <= '0;
      pos_q      <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      if (sample_en) begin
        if (last_sample || pos_q == PCNT_W'(WORD_WIDTH - 1)) begin
          rb_data_q  <= acc_d;
          rb_valid_q <= 1'b1;
          acc_q      <= '0;
          pos_q      <= '0;
        end else begin
          acc_q <= acc_d;
          pos_q <= pos_q + PCNT_W'(1);
        end
      end
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan-chain load controller: accepts configuration words and shifts them
// LSB-first into a CHAIN_LEN-bit chain, pausing between words.
// Optional readback of the displaced chain contents: SCAN_CHAIN_READBACK_EN.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | cfg_ready high, waiting for a word
// SHIFT | one bit of the held word on scan_in per cycle
// DONE  | one-cycle done pulse, then back to IDLE
module scan_chain_ctrl
  import scan_chain_pkg::*;
#(
  parameter int CHAIN_LEN  = 64,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  scan_en,
  output logic                  scan_in,
  input  logic                  scan_out,
  output logic                  busy,
  output logic                  done
`ifdef SCAN_CHAIN_READBACK_EN
  ,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid
`endif
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W = $clog2(WORD_WIDTH + 1);

  state_e                state_q;
  logic [CNT_W-1:0]      bits_left_q;
  logic [WCNT_W-1:0]     wbits_left_q;
  logic [WORD_WIDTH-1:0] word_q;
  logic                  scan_en_q, scan_in_q, cfg_ready_q, done_q;
  logic                  abort_hit;

  assign abort_hit = abort && (state_q != IDLE);

  // Sequencing FSM: both counters count down to zero; bits_left hitting zero
  // ends the load, which also truncates the final word.
  always_ff @(posedge clk) begin
    if (reset || abort_hit) begin
      state_q      <= IDLE;
      bits_left_q  <= '0;
      wbits_left_q <= '0;
      word_q       <= '0;
      scan_en_q    <= 1'b0;
      scan_in_q    <= 1'b0;
      cfg_ready_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= LOAD;
            cfg_ready_q <= 1'b1;
            bits_left_q <= CNT_W'(CHAIN_LEN);
          end
        end
        LOAD: begin
          if (cfg_valid && cfg_ready_q) begin
            state_q      <= SHIFT;
            cfg_ready_q  <= 1'b0;
            scan_en_q    <= 1'b1;
            scan_in_q    <= cfg_data[0];
            word_q       <= cfg_data >> 1;
            bits_left_q  <= bits_left_q - CNT_W'(1);
            wbits_left_q <= WCNT_W'(WORD_WIDTH - 1);
          end
        end
        SHIFT: begin
          if (bits_left_q == '0) begin
            state_q   <= DONE;
            scan_en_q <= 1'b0;
            scan_in_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (wbits_left_q == '0) begin
            state_q     <= LOAD;
            scan_en_q   <= 1'b0;
            scan_in_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
          end else begin
            scan_in_q    <= word_q[0];
            word_q       <= word_q >> 1;
            bits_left_q  <= bits_left_q - CNT_W'(1);
            wbits_left_q <= wbits_left_q - WCNT_W'(1);
          end
        end
        DONE: begin
          state_q      <= IDLE;
          done_q       <= 1'b0;
          bits_left_q  <= '0;
          wbits_left_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign scan_en   = scan_en_q;
  assign scan_in   = scan_in_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

`ifdef SCAN_CHAIN_READBACK_EN
  scan_chain_readback #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_readback (
    .clk        (clk),
    .reset      (reset),
    .clr        (abort_hit),
    .sample_en  (scan_en_q),
    .last_sample(scan_en_q && (bits_left_q == '0)),
    .scan_out   (scan_out),
    .rb_data    (rb_data),
    .rb_valid   (rb_valid)
  );
`else
  logic unused_scan_out;
  assign unused_scan_out = scan_out;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl driving a 20-bit scan chain model.
module tb_scan_chain_ctrl;

  localparam int CL = 20;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [WW-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready, scan_en, scan_in, scan_out, busy, done;
`ifdef SCAN_CHAIN_READBACK_EN
  logic [WW-1:0] rb_data;
  logic          rb_valid;
`endif

  logic [CL-1:0] chain = '0;
  logic [CL-1:0] preload_val = '0;
  logic          preload_req = 1'b0;

  logic          exp_q[$];
  logic [WW-1:0] rb_q[$];
  logic          exp_bit;
  logic [WW-1:0] exp_rb;
  bit            rb_on = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            en_cnt = 0;
  int            done_cnt = 0;
  int            rb_cnt = 0;
  int            bits_rem = 0;

  scan_chain_ctrl #(.CHAIN_LEN(CL), .WORD_WIDTH(WW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .cfg_data (cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .scan_out (scan_out),
    .busy     (busy),
    .done     (done)
`ifdef SCAN_CHAIN_READBACK_EN
    ,
    .rb_data  (rb_data),
    .rb_valid (rb_valid)
`endif
  );

  always #5 clk = ~clk;

  // Chain model: bits enter at the head and move toward position 0 (tail).
  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (scan_en) chain <= {scan_in, chain[CL-1:1]};
  end
  assign scan_out = chain[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every shifted bit and every readback word.
  always @(negedge clk) begin
    if (!reset) begin
      if (scan_en) begin
        en_cnt++;
        if (exp_q.size() == 0) check("extra_shift", 32'(1), 32'(0));
        else begin
          exp_bit = exp_q.pop_front();
          check("scan_in", 32'(scan_in), 32'(exp_bit));
        end
      end
      if (done) done_cnt++;
`ifdef SCAN_CHAIN_READBACK_EN
      if (rb_on && rb_valid) begin
        rb_cnt++;
        if (rb_q.size() == 0) check("extra_rb", 32'(1), 32'(0));
        else begin
          exp_rb = rb_q.pop_front();
          check("rb_data", 32'(rb_data), 32'(exp_rb));
        end
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [CL-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    tick();
    preload_req = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer a word; gap = cycles cfg_valid stays low after cfg_ready rises.
  task automatic send_word(input logic [WW-1:0] w, input int gap);
    int n;
    n = (bits_rem < WW) ? bits_rem : WW;
    for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
    bits_rem -= n;
    cfg_data  = w;
    cfg_valid = (gap == 0);
    for (int c = 0; c < 100 && !cfg_ready; c++) tick();
    check("ready_timeout", 32'(cfg_ready), 32'(1));
    for (int g = 0; g < gap; g++) begin
      check("gap_scan_en", 32'(scan_en), 32'(0));
      tick();
    end
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("accept_scan_en", 32'(scan_en), 32'(1));
    check("accept_ready", 32'(cfg_ready), 32'(0));
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 100 && busy; c++) tick();
    check("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic clear_counts();
    en_cnt   = 0;
    done_cnt = 0;
    rb_cnt   = 0;
  endtask

  task automatic full_load(input int gap);
    clear_counts();
    preload('0);
    bits_rem = CL;
    pulse_start();
    check("start_busy", 32'(busy), 32'(1));
    check("start_ready", 32'(cfg_ready), 32'(1));
    send_word(8'hA5, gap);
    send_word(8'h3C, gap);
    send_word(8'hF9, gap);
    wait_idle();
    tick();
    check("en_cycles", 32'(en_cnt), 32'(CL));
    check("done_pulses", 32'(done_cnt), 32'(1));
    check("chain", 32'(chain), 32'(20'h93CA5));
    check("exp_left", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_scan_en", 32'(scan_en), 32'(0));
    check("rst_scan_in", 32'(scan_in), 32'(0));
    check("rst_ready", 32'(cfg_ready), 32'(0));

    // Back-to-back words, then with stalled cfg_valid.
    full_load(0);
    full_load(5);

    // Abort after ten shifted bits.
    clear_counts();
    preload('0);
    bits_rem = 10;
    pulse_start();
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_scan_en", 32'(scan_en), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_ready", 32'(cfg_ready), 32'(0));
    repeat (5) tick();
    check("abort_en_cycles", 32'(en_cnt), 32'(10));
    check("abort_no_done", 32'(done_cnt), 32'(0));
    check("abort_chain", 32'(chain), 32'(20'h29400));
    check("abort_exp_left", 32'(exp_q.size()), 32'(0));
    pulse_start();
    check("restart_busy", 32'(busy), 32'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_load_busy", 32'(busy), 32'(0));
    full_load(0);

    // Start during SHIFT and LOAD is ignored.
    clear_counts();
    preload('0);
    bits_rem = CL;
    pulse_start();
    send_word(8'hA5, 0);
    pulse_start();
    send_word(8'h3C, 2);
    send_word(8'hF9, 0);
    wait_idle();
    tick();
    check("ign_en_cycles", 32'(en_cnt), 32'(CL));
    check("ign_done", 32'(done_cnt), 32'(1));
    check("ign_chain", 32'(chain), 32'(20'h93CA5));
    repeat (3) tick();
    check("ign_idle", 32'(busy), 32'(0));

    // Reset in the middle of a shift.
    bits_rem = CL;
    pulse_start();
    send_word(8'hA5, 0);
    tick();
    reset = 1'b1;
    tick();
    check("mrst_scan_en", 32'(scan_en), 32'(0));
    check("mrst_scan_in", 32'(scan_in), 32'(0));
    check("mrst_busy", 32'(busy), 32'(0));
    check("mrst_ready", 32'(cfg_ready), 32'(0));
    check("mrst_done", 32'(done), 32'(0));
    reset = 1'b0;
    exp_q.delete();
    tick();

`ifdef SCAN_CHAIN_READBACK_EN
    check("mrst_rb_valid", 32'(rb_valid), 32'(0));
    // Old chain contents of all ones come back as FF, FF, 0F.
    clear_counts();
    preload(20'hFFFFF);
    rb_q.push_back(8'hFF);
    rb_q.push_back(8'hFF);
    rb_q.push_back(8'h0F);
    rb_on = 1'b1;
    bits_rem = CL;
    pulse_start();
    send_word(8'h00, 0);
    send_word(8'h00, 0);
    send_word(8'h00, 0);
    wait_idle();
    repeat (2) tick();
    rb_on = 1'b0;
    check("rb_pulses", 32'(rb_cnt), 32'(3));
    check("rb_left", 32'(rb_q.size()), 32'(0));
    check("rb_chain", 32'(chain), 32'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
